// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared UART receive-side types and default widths
package rx_pkg;

  // Defaults shared with the Rx SIPO and the Tx side
  localparam int DEFAULT_DATA_WIDTH   = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Width of a bit index able to hold 0..width inclusive
  function automatic int bit_idx_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// rtl/rx_bit_timer.sv - per-bit cycle counter with full and half bit terminals
module rx_bit_timer
  import rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic full_term,
  output logic half_term
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic [CW-1:0] cnt;

  // Cycle counter: cleared by the FSM at each sampling point and while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Terminals compared at full width so no wrap is ever treated as an end point
  always_comb begin
    full_term = (cnt == FULL_LAST);
    half_term = (cnt == HALF_LAST);
  end

endmodule

// File: rtl/rx_sampling_control.sv
// rtl/rx_sampling_control.sv - UART receive FSM timing mid-bit samples for the SIPO
module rx_sampling_control
  import rx_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CLKS_PER_BIT     = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic serial_in_synced,
  output logic sampling_strobe,
  output logic data_is_available,
  output logic data_is_valid,
  output logic framing_error,
  output logic rx_busy
);

  localparam int BW = bit_idx_width(INPUT_DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(INPUT_DATA_WIDTH - 1);

  rx_state_t      state;
  rx_state_t      state_next;
  logic [BW-1:0]  bit_idx;
  logic [BW-1:0]  bit_idx_next;
  logic           armed;
  logic           timer_clear;
  logic           full_term;
  logic           half_term;

  rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear),
    .full_term(full_term),
    .half_term(half_term)
  );

  // FSM state and data bit index registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_idx <= '0;
    end else begin
      state   <= state_next;
      bit_idx <= bit_idx_next;
    end
  end

  // armed requires the line to have been seen high, so a break or a reset
  // in the middle of a frame cannot be mistaken for a new start bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed <= 1'b0;
    end else if (framing_error) begin
      armed <= 1'b0;
    end else if (serial_in_synced) begin
      armed <= 1'b1;
    end
  end

  // Next-state and output decode from state, timer terminals and the line
  always_comb begin
    state_next        = state;
    bit_idx_next      = bit_idx;
    timer_clear       = 1'b0;
    sampling_strobe   = 1'b0;
    data_is_valid     = 1'b0;
    framing_error     = 1'b0;
    data_is_available = (state == DATA);
    rx_busy           = (state != IDLE);

    case (state)
      IDLE: begin
        // Hold the timer at zero so START begins counting from cnt = 0
        timer_clear = 1'b1;
        if (armed && !serial_in_synced) begin
          state_next = START;
        end
      end

      START: begin
        if (half_term) begin
          sampling_strobe = 1'b1;
          timer_clear     = 1'b1;
          if (serial_in_synced) begin
            // Line went back high before mid start bit: treat as a glitch
            state_next = IDLE;
          end else begin
            state_next   = DATA;
            bit_idx_next = '0;
          end
        end
      end

      DATA: begin
        if (full_term) begin
          sampling_strobe = 1'b1;
          timer_clear     = 1'b1;
          bit_idx_next    = bit_idx + BW'(1);
          if (bit_idx == LAST_BIT) begin
            state_next = STOP;
          end
        end
      end

      STOP: begin
        if (full_term) begin
          sampling_strobe = 1'b1;
          timer_clear     = 1'b1;
          if (serial_in_synced) begin
            data_is_valid = 1'b1;
          end else begin
            framing_error = 1'b1;
          end
          // Returning at mid stop bit leaves half a bit to catch a back-to-back start edge
          state_next = IDLE;
        end
      end

      default: begin
        state_next  = IDLE;
        timer_clear = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_rx_sampling_control.sv
// tb/tb_rx_sampling_control.sv - directed scoreboard bench for rx_sampling_control
module tb_rx_sampling_control;

  localparam int W        = 8;
  localparam int CPB      = 16;
  localparam int STOP_CYC = CPB / 2 + W * CPB + CPB;
  localparam int FRAME    = (W + 2) * CPB;

  logic clk = 1'b0;
  logic reset;
  logic serial_in_synced;
  logic sampling_strobe;
  logic data_is_available;
  logic data_is_valid;
  logic framing_error;
  logic rx_busy;

  rx_sampling_control #(
    .INPUT_DATA_WIDTH(W),
    .CLKS_PER_BIT    (CPB)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .serial_in_synced (serial_in_synced),
    .sampling_strobe  (sampling_strobe),
    .data_is_available(data_is_available),
    .data_is_valid    (data_is_valid),
    .framing_error    (framing_error),
    .rx_busy          (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] word;
    int         at;
  } ev_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  ev_t  exp_q[$];
  int   strobe_log[$];
  int   avail_cycles = 0;
  logic [7:0] sh = '0;
  int   nbits = 0;
  bit   prev_strobe = 1'b0;
  ev_t  mon_e;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: SIPO model, protocol assertions and scoreboard pop
  always @(negedge clk) begin
    if (reset) begin
      sh          = '0;
      nbits       = 0;
      prev_strobe = 1'b0;
    end else begin
      if (sampling_strobe) begin
        check("strobe_width", {31'd0, prev_strobe}, 32'd0);
        strobe_log.push_back(cyc);
      end
      if (data_is_valid || framing_error)
        check("valid_err_exclusive", {31'd0, data_is_valid && framing_error}, 32'd0);
      if (data_is_available) begin
        check("available_implies_busy", {31'd0, rx_busy}, 32'd1);
        avail_cycles++;
      end
      if (sampling_strobe && data_is_available) begin
        sh = {serial_in_synced, sh[7:1]};
        nbits++;
      end
      if (data_is_valid || framing_error) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("event_kind", {31'd0, framing_error}, {31'd0, mon_e.is_err});
          check("event_cycle", cyc, mon_e.at);
          if (!mon_e.is_err) begin
            check("word", {24'd0, sh}, {24'd0, mon_e.word});
            check("bit_count", nbits, W);
          end
        end
        nbits = 0;
      end
      prev_strobe = sampling_strobe;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives the first ncyc cycles of a frame starting now; pushes the expected outcome
  task automatic send_frame(input logic [7:0] w, input bit stop_bit, input int ncyc, input bit expect_event);
    int c0;
    int b;
    c0 = cyc;
    if (expect_event) exp_q.push_back('{is_err: !stop_bit, word: w, at: c0 + STOP_CYC});
    for (int i = 0; i < ncyc; i++) begin
      b = i / CPB;
      if (b == 0) serial_in_synced = 1'b0;
      else if (b <= W) serial_in_synced = w[b-1];
      else serial_in_synced = stop_bit;
      tick(1);
    end
  endtask

  initial begin
    int c0;
    int av0;

    reset = 1'b1;
    serial_in_synced = 1'b1;
    tick(2);
    check("rst_strobe", {31'd0, sampling_strobe}, 32'd0);
    check("rst_available", {31'd0, data_is_available}, 32'd0);
    check("rst_valid", {31'd0, data_is_valid}, 32'd0);
    check("rst_error", {31'd0, framing_error}, 32'd0);
    check("rst_busy", {31'd0, rx_busy}, 32'd0);
    reset = 1'b0;
    tick(4);

    // 1: good frame 0xA5, strobe timing
    strobe_log.delete();
    c0 = cyc;
    send_frame(8'hA5, 1'b1, FRAME, 1'b1);
    check("t1_strobe_count", strobe_log.size(), W + 2);
    if (strobe_log.size() == W + 2) begin
      check("t1_start_strobe", strobe_log[0], c0 + CPB / 2);
      for (int k = 0; k < W; k++)
        check("t1_data_strobe", strobe_log[k+1], c0 + CPB / 2 + CPB + CPB * k);
      check("t1_stop_strobe", strobe_log[W+1], c0 + STOP_CYC);
    end
    check("t1_queue_empty", exp_q.size(), 0);
    tick(4);

    // 2: short low glitch rejected at the start strobe
    av0 = avail_cycles;
    serial_in_synced = 1'b0;
    tick(3);
    serial_in_synced = 1'b1;
    tick(5);
    check("t2_start_strobe", {31'd0, sampling_strobe}, 32'd1);
    check("t2_busy_at_strobe", {31'd0, rx_busy}, 32'd1);
    check("t2_no_available", {31'd0, data_is_available}, 32'd0);
    tick(1);
    check("t2_back_idle", {31'd0, rx_busy}, 32'd0);
    tick(8);
    check("t2_no_data_cycles", avail_cycles, av0);

    // 3: framing error, line held low, then recovery
    send_frame(8'h3C, 1'b0, FRAME, 1'b1);
    serial_in_synced = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      check("t3_break_ignored", {31'd0, rx_busy}, 32'd0);
    end
    serial_in_synced = 1'b1;
    tick(16);
    send_frame(8'h81, 1'b1, FRAME, 1'b1);
    tick(4);
    check("t3_queue_empty", exp_q.size(), 0);

    // 4: back-to-back frames, no gap
    send_frame(8'h00, 1'b1, FRAME, 1'b1);
    send_frame(8'hFF, 1'b1, FRAME, 1'b1);
    tick(4);
    check("t4_queue_empty", exp_q.size(), 0);

    // 5: reset in the middle of a frame
    send_frame(8'h55, 1'b1, 59, 1'b0);
    check("t5_busy_before", {31'd0, rx_busy}, 32'd1);
    check("t5_available_before", {31'd0, data_is_available}, 32'd1);
    tick(1);
    reset = 1'b1;
    #1;
    check("t5_rst_busy", {31'd0, rx_busy}, 32'd0);
    check("t5_rst_available", {31'd0, data_is_available}, 32'd0);
    check("t5_rst_strobe", {31'd0, sampling_strobe}, 32'd0);
    check("t5_rst_valid", {31'd0, data_is_valid}, 32'd0);
    check("t5_rst_error", {31'd0, framing_error}, 32'd0);
    tick(2);
    reset = 1'b0;
    serial_in_synced = 1'b1;
    tick(32);
    send_frame(8'h5A, 1'b1, FRAME, 1'b1);
    tick(8);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
